branch_flag_unit: RTL and testbench
===================================

# branch_flag_unit

Consumer end of the ALU flag interface: it latches the zero/negative/overflow/carryOut outputs of the 64-bit ALU into an architectural NZCV register when a flag-setting instruction (ADDS, SUBS, ANDS) retires from EX. It resolves B.cond, CBZ and CBNZ against those flags, producing a registered branch-taken decision for the fetch stage. A two-state squash machine kills the wrong-path instruction that follows a taken branch, and a saturating counter records taken branches for debug.

## Interface
- CNT_W, 16, width of the taken-branch counter.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low (asserted at 0).
- valid_in  in  1  EX-stage instruction valid.
- stall  in  1  pipeline hold; no state advances except by reset/flush.
- flush  in  1  external pipeline flush (exception path).
- setFlags  in  1  instruction writes NZCV.
- zero, negative, overflow, carryOut  in  1 each  ALU flag outputs for the EX instruction.
- brType  in  2  00 none, 01 B.cond, 10 CBZ, 11 CBNZ.
- cond  in  4  LEGv8 condition field for B.cond.
- taken  out  1  registered branch-taken decision.
- taken_valid  out  1  taken is meaningful this cycle.
- flags_q  out  4  architectural {N,Z,C,V}.
- squashing  out  1  high in SQUASH state.
- br_count  out  CNT_W  saturating count of taken branches.

## Operation
- Accept = valid_in & ~stall & ~flush & ~squashing.
- Flag write: on accept & setFlags, flags_q <= {negative, zero, carryOut, overflow}. Not written on non-accepted cycles.
- CBZ: taken = zero (operand passed through ALU). CBNZ: taken = ~zero. Both use current ALU zero, never flags_q.
- B.cond evaluates flags_q (value before this edge; flag-setting instruction and B.cond never coexist). Codes: 0 EQ Z; 1 NE ~Z; 2 HS C; 3 LO ~C; 4 MI N; 5 PL ~N; 6 VS V; 7 VC ~V; 8 HI C&~Z; 9 LS ~(C&~Z); 10 GE N==V; 11 LT N!=V; 12 GT ~Z&(N==V); 13 LE ~(~Z&(N==V)); 14 AL 1; 15 NV 1.
- brType 00: taken_valid <= 1 on accept with taken <= 0.
- States: IDLE, SQUASH. IDLE -> SQUASH on accept with resolved taken=1. SQUASH -> IDLE on the next cycle with valid_in & ~stall (that instruction is killed: no flag write, no branch evaluation, taken_valid <= 0). SQUASH holds while stall or ~valid_in.
- Flush: state <= IDLE, taken_valid <= 0, taken <= 0; flags_q and br_count unchanged. Flush has priority over stall and over accept.
- br_count increments on each accepted taken branch; saturates at all-ones.

## Timing
- Reset (async, reset=0): flags_q=0000, taken=0, taken_valid=0, state IDLE (squashing=0), br_count=0. Deassertion takes effect on the first following rising edge.
- Latency: one cycle. Inputs sampled at edge k; taken/taken_valid/flags_q visible after edge k.
- taken_valid is a single-cycle pulse per accepted instruction; it drops to 0 on any edge that does not accept (including stall cycles, SQUASH kills, flush).
- Stall: taken, flags_q, state, br_count hold; taken_valid <= 0.
- Back-to-back: flag-setting instruction at edge k, B.cond at edge k+1 sees the new flags_q.
- Reset asserted mid-SQUASH returns to IDLE immediately; the pending kill is dropped.

## Test plan
- Reset: hold reset=0 with random inputs -> all outputs 0. Release, apply SUBS (setFlags=1, zero=1, carryOut=1) -> flags_q=0110 after one edge.
- Conditions: preload each of the 16 NZCV values via setFlags, then issue B.cond for all 16 codes -> taken matches the table (e.g., NZCV=1000, GE -> 0, LT -> 1).
- CBZ/CBNZ: zero=1 with brType=10 -> taken=1, squashing=1. The next valid instruction, a SUBS with zero=0, is killed: flags_q unchanged, taken_valid=0, state returns to IDLE.
- Stall: accept taken B.cond, then raise stall for 3 cycles with a new valid_in -> state stays SQUASH, taken_valid=0, flags_q unchanged. The first unstalled valid instruction is killed.
- Flush: flush=1 while in SQUASH with a simultaneous valid setFlags -> state IDLE, taken_valid=0, no flag write.
- Counter: CNT_W=4, issue 20 taken CBZ instructions, each separated by one squashed instruction -> br_count=15 (saturated).

Source files
------------

// File: rtl/branch_flag_unit.sv
// rtl/branch_flag_unit.sv - NZCV flag register, branch resolution, squash FSM and taken counter
//
// Latches ALU flags into an architectural NZCV register on flag-setting
// instructions, resolves B.cond / CBZ / CBNZ, kills the wrong-path
// instruction after a taken branch and counts taken branches.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   valid_in     EX-stage instruction valid
//   stall        pipeline hold
//   flush        pipeline flush (exception path)
//   setFlags     instruction writes NZCV
//   zero, negative, overflow, carryOut   ALU flags for the EX instruction
//   brType       00 none, 01 B.cond, 10 CBZ, 11 CBNZ
//   cond         B.cond condition code
//   taken        registered branch-taken decision
//   taken_valid  single-cycle pulse per accepted instruction
//   flags_q      architectural {N,Z,C,V}
//   squashing    high while the next instruction is to be killed
//   br_count     saturating count of taken branches
module branch_flag_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic             stall,
    input  logic             flush,
    input  logic             setFlags,
    input  logic             zero,
    input  logic             negative,
    input  logic             overflow,
    input  logic             carryOut,
    input  logic [1:0]       brType,
    input  logic [3:0]       cond,
    output logic             taken,
    output logic             taken_valid,
    output logic [3:0]       flags_q,
    output logic             squashing,
    output logic [CNT_W-1:0] br_count
);

    typedef enum logic {
        IDLE   = 1'b0,
        SQUASH = 1'b1
    } state_t;

    state_t state, next_state;

    logic accept;
    logic cond_true;
    logic resolved;
    logic fn, fz, fc, fv;

    assign fn = flags_q[3];
    assign fz = flags_q[2];
    assign fc = flags_q[1];
    assign fv = flags_q[0];

    assign squashing = (state == SQUASH);
    assign accept    = valid_in & ~stall & ~flush & ~squashing;

    // B.cond looks at the registered flags; a flag-setting instruction and a
    // B.cond never share a cycle, so the pre-edge value is the right one.
    always_comb begin
        cond_true = 1'b0;
        case (cond)
            4'd0:    cond_true = fz;
            4'd1:    cond_true = ~fz;
            4'd2:    cond_true = fc;
            4'd3:    cond_true = ~fc;
            4'd4:    cond_true = fn;
            4'd5:    cond_true = ~fn;
            4'd6:    cond_true = fv;
            4'd7:    cond_true = ~fv;
            4'd8:    cond_true = fc & ~fz;
            4'd9:    cond_true = ~(fc & ~fz);
            4'd10:   cond_true = (fn == fv);
            4'd11:   cond_true = (fn != fv);
            4'd12:   cond_true = ~fz & (fn == fv);
            4'd13:   cond_true = ~(~fz & (fn == fv));
            default: cond_true = 1'b1;
        endcase
    end

    // CBZ/CBNZ pass the operand through the ALU, so they use the live zero flag.
    always_comb begin
        resolved = 1'b0;
        case (brType)
            2'b01:   resolved = cond_true;
            2'b10:   resolved = zero;
            2'b11:   resolved = ~zero;
            default: resolved = 1'b0;
        endcase
    end

    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept && resolved) next_state = SQUASH;
                SQUASH:  if (valid_in && !stall) next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            taken       <= 1'b0;
            taken_valid <= 1'b0;
            flags_q     <= 4'b0000;
            br_count    <= '0;
        end else if (flush) begin
            taken       <= 1'b0;
            taken_valid <= 1'b0;
        end else if (accept) begin
            taken       <= resolved;
            taken_valid <= 1'b1;
            if (setFlags) begin
                flags_q <= {negative, zero, carryOut, overflow};
            end
            if (resolved && (br_count != {CNT_W{1'b1}})) begin
                br_count <= br_count + CNT_W'(1);
            end
        end else begin
            // Stalls and squash kills: decision holds, but it is no longer fresh.
            taken_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_branch_flag_unit.sv
// tb/tb_branch_flag_unit.sv - self-checking bench for branch_flag_unit
module tb_branch_flag_unit;

    localparam int CNT_W = 4;

    logic             clk;
    logic             reset;
    logic             valid_in;
    logic             stall;
    logic             flush;
    logic             setFlags;
    logic             zero;
    logic             negative;
    logic             overflow;
    logic             carryOut;
    logic [1:0]       brType;
    logic [3:0]       cond;
    logic             taken;
    logic             taken_valid;
    logic [3:0]       flags_q;
    logic             squashing;
    logic [CNT_W-1:0] br_count;

    int total = 0;
    int bad   = 0;

    branch_flag_unit #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .valid_in    (valid_in),
        .stall       (stall),
        .flush       (flush),
        .setFlags    (setFlags),
        .zero        (zero),
        .negative    (negative),
        .overflow    (overflow),
        .carryOut    (carryOut),
        .brType      (brType),
        .cond        (cond),
        .taken       (taken),
        .taken_valid (taken_valid),
        .flags_q     (flags_q),
        .squashing   (squashing),
        .br_count    (br_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] nzcv;
        logic [3:0] code;
        logic       exp;
    } cond_vec_t;

    cond_vec_t vecs [32];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one unstalled, unflushed valid instruction for one edge.
    task automatic instr(input logic sf, input logic [3:0] nzcv, input logic [1:0] bt, input logic [3:0] cd);
        valid_in = 1'b1;
        stall    = 1'b0;
        flush    = 1'b0;
        setFlags = sf;
        negative = nzcv[3];
        zero     = nzcv[2];
        carryOut = nzcv[1];
        overflow = nzcv[0];
        brType   = bt;
        cond     = cd;
        step();
    endtask

    task automatic idle_inputs();
        valid_in = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        setFlags = 1'b0;
        negative = 1'b0;
        zero     = 1'b0;
        carryOut = 1'b0;
        overflow = 1'b0;
        brType   = 2'b00;
        cond     = 4'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    initial begin
        // {NZCV, cond, expected taken}
        vecs[0]  = '{4'b0100, 4'd0,  1'b1};
        vecs[1]  = '{4'b0000, 4'd0,  1'b0};
        vecs[2]  = '{4'b0100, 4'd1,  1'b0};
        vecs[3]  = '{4'b0000, 4'd1,  1'b1};
        vecs[4]  = '{4'b0010, 4'd2,  1'b1};
        vecs[5]  = '{4'b0000, 4'd2,  1'b0};
        vecs[6]  = '{4'b0010, 4'd3,  1'b0};
        vecs[7]  = '{4'b1101, 4'd3,  1'b1};
        vecs[8]  = '{4'b1000, 4'd4,  1'b1};
        vecs[9]  = '{4'b0111, 4'd4,  1'b0};
        vecs[10] = '{4'b1000, 4'd5,  1'b0};
        vecs[11] = '{4'b0111, 4'd5,  1'b1};
        vecs[12] = '{4'b0001, 4'd6,  1'b1};
        vecs[13] = '{4'b1110, 4'd6,  1'b0};
        vecs[14] = '{4'b0001, 4'd7,  1'b0};
        vecs[15] = '{4'b1110, 4'd7,  1'b1};
        vecs[16] = '{4'b0010, 4'd8,  1'b1};
        vecs[17] = '{4'b0110, 4'd8,  1'b0};
        vecs[18] = '{4'b0110, 4'd9,  1'b1};
        vecs[19] = '{4'b1010, 4'd9,  1'b0};
        vecs[20] = '{4'b1000, 4'd10, 1'b0};
        vecs[21] = '{4'b1001, 4'd10, 1'b1};
        vecs[22] = '{4'b1000, 4'd11, 1'b1};
        vecs[23] = '{4'b0000, 4'd11, 1'b0};
        vecs[24] = '{4'b0000, 4'd12, 1'b1};
        vecs[25] = '{4'b0100, 4'd12, 1'b0};
        vecs[26] = '{4'b1000, 4'd12, 1'b0};
        vecs[27] = '{4'b1000, 4'd13, 1'b1};
        vecs[28] = '{4'b0001, 4'd13, 1'b1};
        vecs[29] = '{4'b1001, 4'd13, 1'b0};
        vecs[30] = '{4'b0000, 4'd14, 1'b1};
        vecs[31] = '{4'b0000, 4'd15, 1'b1};

        // Reset held with random inputs: every output stays zero.
        idle_inputs();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            valid_in = 1'($urandom);
            stall    = 1'($urandom);
            flush    = 1'($urandom);
            setFlags = 1'($urandom);
            negative = 1'($urandom);
            zero     = 1'($urandom);
            carryOut = 1'($urandom);
            overflow = 1'($urandom);
            brType   = 2'($urandom);
            cond     = 4'($urandom);
            step();
            check("rst_outputs", {taken, taken_valid, flags_q, squashing, br_count}, 16'h0);
        end
        idle_inputs();
        reset = 1'b1;

        // First SUBS after release: Z and C set.
        instr(1'b1, 4'b0110, 2'b00, 4'd0);
        check("subs_flags", 16'(flags_q), 16'h6);
        check("subs_tv", 16'(taken_valid), 16'h1);
        check("subs_taken", 16'(taken), 16'h0);
        idle_inputs();
        step();
        check("tv_pulse_drop", 16'(taken_valid), 16'h0);

        // Condition table: preload flags, B.cond on the very next edge.
        for (int i = 0; i < 32; i++) begin
            instr(1'b1, vecs[i].nzcv, 2'b00, 4'd0);
            check($sformatf("pre_flags[%0d]", i), 16'(flags_q), 16'(vecs[i].nzcv));
            instr(1'b0, ~vecs[i].nzcv, 2'b01, vecs[i].code);
            check($sformatf("bcond_taken[%0d]", i), 16'(taken), 16'(vecs[i].exp));
            check($sformatf("bcond_tv[%0d]", i), 16'(taken_valid), 16'h1);
            check($sformatf("bcond_sq[%0d]", i), 16'(squashing), 16'(vecs[i].exp));
            if (vecs[i].exp) begin
                instr(1'b1, ~vecs[i].nzcv, 2'b00, 4'd0);
                check($sformatf("kill_flags[%0d]", i), 16'(flags_q), 16'(vecs[i].nzcv));
                check($sformatf("kill_tv[%0d]", i), 16'(taken_valid), 16'h0);
                check($sformatf("kill_sq[%0d]", i), 16'(squashing), 16'h0);
            end
        end

        // CBZ / CBNZ against live zero, then a SUBS that gets killed.
        instr(1'b1, 4'b0000, 2'b00, 4'd0);
        instr(1'b0, 4'b0100, 2'b10, 4'd0);
        check("cbz_taken", 16'(taken), 16'h1);
        check("cbz_sq", 16'(squashing), 16'h1);
        instr(1'b1, 4'b1011, 2'b00, 4'd0);
        check("cbz_kill_flags", 16'(flags_q), 16'h0);
        check("cbz_kill_tv", 16'(taken_valid), 16'h0);
        check("cbz_kill_sq", 16'(squashing), 16'h0);
        instr(1'b0, 4'b0000, 2'b10, 4'd0);
        check("cbz_nt", {15'h0, taken}, 16'h0);
        check("cbz_nt_sq", 16'(squashing), 16'h0);
        instr(1'b0, 4'b0100, 2'b11, 4'd0);
        check("cbnz_nt", 16'(taken), 16'h0);
        instr(1'b0, 4'b0000, 2'b11, 4'd0);
        check("cbnz_taken", 16'(taken), 16'h1);
        check("cbnz_sq", 16'(squashing), 16'h1);
        instr(1'b0, 4'b0000, 2'b00, 4'd0);
        check("cbnz_kill_sq", 16'(squashing), 16'h0);

        // Stall while squashing: everything holds; first unstalled instr is killed.
        instr(1'b1, 4'b0101, 2'b00, 4'd0);
        instr(1'b0, 4'b0000, 2'b01, 4'd14);
        check("st_taken0", 16'(taken), 16'h1);
        for (int i = 0; i < 3; i++) begin
            valid_in = 1'b1;
            stall    = 1'b1;
            setFlags = 1'b1;
            negative = 1'b1;
            zero     = 1'b0;
            carryOut = 1'b1;
            overflow = 1'b0;
            brType   = 2'b10;
            step();
            check($sformatf("st_sq[%0d]", i), 16'(squashing), 16'h1);
            check($sformatf("st_tv[%0d]", i), 16'(taken_valid), 16'h0);
            check($sformatf("st_flags[%0d]", i), 16'(flags_q), 16'h5);
            check($sformatf("st_taken[%0d]", i), 16'(taken), 16'h1);
        end
        instr(1'b1, 4'b1010, 2'b00, 4'd0);
        check("st_kill_flags", 16'(flags_q), 16'h5);
        check("st_kill_tv", 16'(taken_valid), 16'h0);
        check("st_kill_sq", 16'(squashing), 16'h0);
        instr(1'b1, 4'b1010, 2'b00, 4'd0);
        check("st_after_flags", 16'(flags_q), 16'hA);
        check("st_after_tv", 16'(taken_valid), 16'h1);

        // Flush during SQUASH with a valid flag-setting instruction.
        instr(1'b0, 4'b0100, 2'b10, 4'd0);
        check("fl_pre_sq", 16'(squashing), 16'h1);
        valid_in = 1'b1;
        flush    = 1'b1;
        setFlags = 1'b1;
        negative = 1'b0;
        zero     = 1'b1;
        carryOut = 1'b0;
        overflow = 1'b1;
        brType   = 2'b10;
        step();
        check("fl_sq", 16'(squashing), 16'h0);
        check("fl_tv", 16'(taken_valid), 16'h0);
        check("fl_taken", 16'(taken), 16'h0);
        check("fl_flags", 16'(flags_q), 16'hA);
        // Flush in IDLE also blocks the flag write.
        step();
        check("fl_idle_flags", 16'(flags_q), 16'hA);
        check("fl_idle_sq", 16'(squashing), 16'h0);
        flush = 1'b0;

        // Reset asserted mid-SQUASH clears state immediately.
        instr(1'b0, 4'b0100, 2'b10, 4'd0);
        check("rs_pre_sq", 16'(squashing), 16'h1);
        idle_inputs();
        #2;
        reset = 1'b0;
        #1;
        check("rs_async_sq", 16'(squashing), 16'h0);
        check("rs_async_flags", 16'(flags_q), 16'h0);
        check("rs_async_cnt", 16'(br_count), 16'h0);
        step();
        reset = 1'b1;
        instr(1'b1, 4'b0011, 2'b00, 4'd0);
        check("rs_not_killed", 16'(flags_q), 16'h3);
        check("rs_tv", 16'(taken_valid), 16'h1);

        // Saturating counter: 20 taken CBZ, each followed by a killed instr.
        do_reset();
        check("cnt_start", 16'(br_count), 16'h0);
        for (int i = 0; i < 20; i++) begin
            instr(1'b0, 4'b0100, 2'b10, 4'd0);
            check($sformatf("cnt[%0d]", i), 16'(br_count), 16'((i + 1 > 15) ? 15 : i + 1));
            instr(1'b0, 4'b0100, 2'b10, 4'd0);
            check($sformatf("cnt_kill[%0d]", i), 16'(br_count), 16'((i + 1 > 15) ? 15 : i + 1));
        end
        // Not-taken branch leaves the counter alone.
        instr(1'b0, 4'b0000, 2'b10, 4'd0);
        check("cnt_nt", 16'(br_count), 16'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
